mem_port_arbiter: RTL

Arbiter and sequencer sharing one single-ported, variable-latency unified memory between the instruction-fetch path (PC/IF stage) and the data-access path (EX/MEM stage) of the 5-stage pipelined datapath. It grants one requester at a time, drives the memory request/acknowledge handshake, returns read data, and generates the stall signals that freeze the pipeline while an access is outstanding. Data accesses normally win; a bounded starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and bus signal around the shared unified-memory
// arbiter: the instruction-fetch requester, the data-access requester, the
// single-ported memory and the two pipeline stall outputs.
//
//   Fetch side : if_req, if_addr            -> arbiter
//                if_rdata, if_done          <- arbiter
//   Data side  : d_rd, d_wr, d_addr, d_wdata -> arbiter
//                d_rdata, d_done            <- arbiter
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata <- arbiter
//                mem_rdata, mem_ack         -> arbiter
//   Pipeline   : stall_if, stall_mem        <- arbiter
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment around it (pipeline requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    // Data requester
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Pipeline freeze
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_rd, d_wr, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_rd, d_wr, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency unified memory between the
// instruction-fetch path and the data-access path of a 5-stage pipeline.
// One requester is granted at a time; the granted address/control is
// registered onto the memory port and held until mem_ack, the returned word
// is captured for the owner, and a one-cycle done pulse is raised for it.
// Data accesses normally win arbitration; a saturating starvation counter
// forces a fetch grant after STARVE_MAX consecutive data grants that left a
// fetch waiting.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low; clears all state on a clock edge
//   bus    - mem_port_arbiter_if.slave (fetch, data, memory, stall signals)
//
// Parameters:
//   ADDR_W, DATA_W - address / data width (must match the bus instance)
//   STARVE_MAX     - data grants tolerated with a fetch waiting (>= 1)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_port_arbiter_if.slave       bus
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t             state_reg;
    logic               mem_req_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic [DATA_W-1:0]  if_rdata_reg;
    logic [DATA_W-1:0]  d_rdata_reg;
    logic               if_done_reg;
    logic               d_done_reg;
    logic [CNT_W-1:0]   starve_cnt_reg;

    // A requester whose done pulse is high this cycle still shows its
    // request (the pipeline only advances on the following edge), so it is
    // masked out to avoid re-issuing the access that just completed.
    logic data_pend;
    logic fetch_pend;
    logic starve_hit;
    logic grant_fetch;
    logic grant_data;

    assign data_pend   = (bus.d_rd | bus.d_wr) & ~d_done_reg;
    assign fetch_pend  = bus.if_req & ~if_done_reg;
    assign starve_hit  = (starve_cnt_reg == STARVE_LIMIT);

    // Data wins unless the fetch has been passed over STARVE_MAX times.
    assign grant_fetch = fetch_pend & (~data_pend | starve_hit);
    assign grant_data  = data_pend & ~grant_fetch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_done_reg    <= 1'b0;
            d_done_reg     <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            // Done flags are single-cycle pulses by default.
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // mem_ack arriving here belongs to no access; ignore it.
                    if (grant_fetch) begin
                        state_reg      <= ST_FETCH;
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= 1'b0;
                        mem_addr_reg   <= bus.if_addr;
                        mem_wdata_reg  <= bus.d_wdata;
                        starve_cnt_reg <= '0;
                    end else if (grant_data) begin
                        state_reg      <= ST_DATA;
                        mem_req_reg    <= 1'b1;
                        // Read and write together is treated as a write.
                        mem_we_reg     <= bus.d_wr;
                        mem_addr_reg   <= bus.d_addr;
                        mem_wdata_reg  <= bus.d_wdata;
                        if (fetch_pend && !starve_hit) begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (bus.mem_ack) begin
                        state_reg    <= ST_IDLE;
                        mem_req_reg  <= 1'b0;
                        if_rdata_reg <= bus.mem_rdata;
                        if_done_reg  <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bus.mem_ack) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                        // The registered write flag is used rather than the
                        // live request so a dropped request cannot change
                        // how the granted access completes.
                        if (!mem_we_reg) begin
                            d_rdata_reg <= bus.mem_rdata;
                        end
                        d_done_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.if_done   = if_done_reg;
    assign bus.d_done    = d_done_reg;

    // Stalls are combinational so the pipeline freezes in the same cycle a
    // request appears; the done pulse releases it on the completion cycle.
    assign bus.stall_mem = (bus.d_rd | bus.d_wr) & ~d_done_reg;
    assign bus.stall_if  = (bus.if_req & ~if_done_reg) | bus.stall_mem;

endmodule
